// File: rtl/hist_eq_phase_seq.sv
// Phase sequencer for the histogram-equalisation pipeline: HIST -> CDF -> DIV -> MAP -> DONE,
// with a per-phase watchdog, abort, error capture and a completed-frame counter.
module hist_eq_phase_seq #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int WD_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        hist_done,
  input  logic        cdf_done,
  input  logic        div_sc_mem_wt_done,
  input  logic        output_wt_done,
  output logic        hist_en,
  output logic        cdf_en,
  output logic        div_en,
  output logic        map_en,
  output logic        map_start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_phase,
  output logic [2:0]  phase,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HIST = 3'd1,
    S_CDF  = 3'd2,
    S_DIV  = 3'd3,
    S_MAP  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WD_W-1:0] wd;
  logic [WD_W-1:0] wd_nxt;
  logic [2:0]      err_nxt;
  logic            active;
  logic            phase_done;

  always_comb begin
    state_nxt  = state;
    err_nxt    = err_phase;
    active     = (state == S_HIST) || (state == S_CDF) || (state == S_DIV) || (state == S_MAP);
    phase_done = 1'b0;
    case (state)
      S_HIST:  phase_done = hist_done;
      S_CDF:   phase_done = cdf_done;
      S_DIV:   phase_done = div_sc_mem_wt_done;
      S_MAP:   phase_done = output_wt_done;
      default: phase_done = 1'b0;
    endcase

    // Priority inside an active phase: abort, then the phase's own done, then the watchdog.
    case (state)
      S_IDLE: if (start) state_nxt = S_HIST;
      S_HIST, S_CDF, S_DIV, S_MAP: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (phase_done) begin
          state_nxt = state_t'(state + 3'd1);
        end else if (wd == WD_LAST) begin
          state_nxt = S_ERR;
          err_nxt   = state;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      S_ERR: begin
        if (start) begin
          state_nxt = S_HIST;
          err_nxt   = 3'd0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt != state) wd_nxt = '0;
    else if (active)        wd_nxt = wd + 1'b1;
    else                    wd_nxt = wd;
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wd        <= '0;
      err_phase <= 3'd0;
      hist_en   <= 1'b0;
      cdf_en    <= 1'b0;
      div_en    <= 1'b0;
      map_en    <= 1'b0;
      map_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      phase     <= 3'd0;
      frame_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      wd        <= wd_nxt;
      err_phase <= err_nxt;
      hist_en   <= (state_nxt == S_HIST);
      cdf_en    <= (state_nxt == S_CDF);
      div_en    <= (state_nxt == S_DIV);
      map_en    <= (state_nxt == S_MAP);
      map_start <= (state_nxt == S_MAP) && (state != S_MAP);
      busy      <= (state_nxt == S_HIST) || (state_nxt == S_CDF) || (state_nxt == S_DIV) ||
                   (state_nxt == S_MAP)  || (state_nxt == S_DONE);
      done      <= (state_nxt == S_DONE);
      error     <= (state_nxt == S_ERR);
      phase     <= state_nxt;
      if (state_nxt == S_DONE) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
